// File: rtl/kbd_scan_if.sv
// Keypad scanner bus: column sense in, row drive and accepted-key reporting out.
interface kbd_scan_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  col,
        output row, key_code, key_valid, key_down
    );

    modport slave (
        output col,
        input  row, key_code, key_valid, key_down
    );
endinterface

// File: rtl/kbd_scan.sv
// 4x4 active-low matrix keypad scanner: row strobe, 2-flop column sync, press/release debounce.
// Define KEY_REPEAT_EN to add auto-repeat pulses on key_valid while a key is held.
module kbd_scan #(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DB_CNT   = 10,
    parameter int unsigned REP_DLY  = 500,
    parameter int unsigned REP_RATE = 100
) (
    input  logic       clk,
    input  logic       rst,
    kbd_scan_if.master kbd
);
    localparam int unsigned CMAX_A = (DB_CNT > REP_DLY) ? DB_CNT : REP_DLY;
    localparam int unsigned CMAX   = (CMAX_A > REP_RATE) ? CMAX_A : REP_RATE;
    localparam int unsigned CW     = $clog2(CMAX + 1);
    localparam int unsigned DW     = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state, state_nx;
    logic [3:0]    col_m, col_s;
    logic [1:0]    r, r_nx;
    logic [1:0]    c, c_nx;
    logic [DW-1:0] dwell, dwell_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    code_q, code_nx;
    logic          valid_q, valid_nx;
    logic          down_q, down_nx;
    logic [1:0]    low_idx;
    logic          col_hit;
`ifdef KEY_REPEAT_EN
    logic          rep, rep_nx;
`endif

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CW'(CMAX)) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            col_m <= 4'hF;
            col_s <= 4'hF;
        end else begin
            col_m <= kbd.col;
            col_s <= col_m;
        end
    end

    // Descending walk so the lowest-index low column wins.
    always_comb begin
        low_idx = 2'd0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (!col_s[i-1]) low_idx = 2'(i - 1);
        end
    end

    assign col_hit = ~col_s[c];

    always_comb begin
        state_nx = state;
        r_nx     = r;
        c_nx     = c;
        dwell_nx = dwell;
        cnt_nx   = cnt;
        code_nx  = code_q;
        valid_nx = 1'b0;
        down_nx  = down_q;
`ifdef KEY_REPEAT_EN
        rep_nx   = rep;
`endif
        case (state)
            SCAN: begin
                if (dwell == DW'(SCAN_DIV - 1)) begin
                    dwell_nx = '0;
                    if (col_s == 4'hF) begin
                        r_nx = r + 2'd1;
                    end else begin
                        c_nx     = low_idx;
                        cnt_nx   = '0;
                        state_nx = DEBOUNCE;
                    end
                end else begin
                    dwell_nx = dwell + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (col_hit) begin
                    if (cnt == CW'(DB_CNT - 1)) begin
                        state_nx = PRESSED;
                        code_nx  = {r, c};
                        valid_nx = 1'b1;
                        down_nx  = 1'b1;
                        cnt_nx   = '0;
`ifdef KEY_REPEAT_EN
                        rep_nx   = 1'b0;
`endif
                    end else begin
                        cnt_nx = sat_inc(cnt);
                    end
                end else begin
                    state_nx = SCAN;
                    r_nx     = r + 2'd1;
                end
            end
            PRESSED: begin
                if (!col_hit) begin
                    state_nx = RELEASE;
                    cnt_nx   = '0;
                end
`ifdef KEY_REPEAT_EN
                // cnt doubles as the hold timer; rep selects first-delay vs. repeat period.
                else if (cnt == (rep ? CW'(REP_RATE - 1) : CW'(REP_DLY - 1))) begin
                    valid_nx = 1'b1;
                    cnt_nx   = '0;
                    rep_nx   = 1'b1;
                end else begin
                    cnt_nx = sat_inc(cnt);
                end
`endif
            end
            RELEASE: begin
                if (!col_hit) begin
                    if (cnt == CW'(DB_CNT - 1)) begin
                        down_nx  = 1'b0;
                        state_nx = SCAN;
                        r_nx     = r + 2'd1;
                    end else begin
                        cnt_nx = sat_inc(cnt);
                    end
                end else begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
`ifdef KEY_REPEAT_EN
                    rep_nx   = 1'b0;
`endif
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SCAN;
            r       <= '0;
            c       <= '0;
            dwell   <= '0;
            cnt     <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep     <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            r       <= r_nx;
            c       <= c_nx;
            dwell   <= dwell_nx;
            cnt     <= cnt_nx;
            code_q  <= code_nx;
            valid_q <= valid_nx;
            down_q  <= down_nx;
`ifdef KEY_REPEAT_EN
            rep     <= rep_nx;
`endif
        end
    end

    assign kbd.row       = ~(4'b0001 << r);
    assign kbd.key_code  = code_q;
    assign kbd.key_valid = valid_q;
    assign kbd.key_down  = down_q;
endmodule
